// File: rtl/jpeg_pkg.sv
// Shared JPEG pipeline constants: component ids, block SRAM geometry and the
// block writer state encoding.
package jpeg_pkg;

  localparam int unsigned COMP_Y          = 0;
  localparam int unsigned COMP_CB         = 1;
  localparam int unsigned COMP_CR         = 2;
  localparam int unsigned NUM_COMPS       = 3;

  localparam int unsigned BLOCKS_PER_COMP = 575;
  localparam int unsigned SRAM_ADDR_W     = 11;
  localparam int unsigned ROWS_PER_BLOCK  = 8;
  localparam int unsigned PIXEL_ROW_W     = 64;
  localparam int unsigned BLOCK_BITS      = ROWS_PER_BLOCK * PIXEL_ROW_W;

  typedef enum logic [2:0] {
    StIdle,
    StRunY,
    StRunCb,
    StRunCr,
    StLastWr,
    StDone
  } writer_state_e;

  // Component whose blocks are streamed while in the given state.
  function automatic logic [1:0] comp_of(writer_state_e st);
    case (st)
      StRunCb: return 2'(COMP_CB);
      StRunCr: return 2'(COMP_CR);
      default: return 2'(COMP_Y);
    endcase
  endfunction

endpackage

// File: rtl/block_row_packer.sv
// Collects block rows into a row buffer and presents the packed block word
// combinationally on the cycle the final row is accepted.
module block_row_packer #(
  parameter int unsigned ROW_W = 64,
  parameter int unsigned ROWS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [ROW_W-1:0]      row,
  output logic [ROWS*ROW_W-1:0] packed_word,
  output logic                  block_complete
);

  localparam int unsigned CNT_W  = $clog2(ROWS);
  localparam int unsigned WORD_W = ROWS * ROW_W;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

  // The final row bypasses the buffer, so only ROWS-1 slots are stored.
  logic [ROW_W-1:0] row_buf_q [ROWS-1];
  logic [CNT_W-1:0] row_cnt_q;

  assign block_complete = accept && (row_cnt_q == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt_q <= '0;
      for (int i = 0; i < int'(ROWS) - 1; i++) begin
        row_buf_q[i] <= '0;
      end
    end else if (clear) begin
      row_cnt_q <= '0;
    end else if (accept) begin
      if (row_cnt_q == LAST_ROW) begin
        row_cnt_q <= '0;
      end else begin
        row_buf_q[row_cnt_q] <= row;
        row_cnt_q            <= row_cnt_q + CNT_W'(1);
      end
    end
  end

  // Row 0 lands in the most significant slice.
  always_comb begin
    packed_word = '0;
    for (int i = 0; i < int'(ROWS) - 1; i++) begin
      packed_word[WORD_W-1-i*ROW_W -: ROW_W] = row_buf_q[i];
    end
    packed_word[ROW_W-1:0] = row;
  end

endmodule

// File: rtl/block_sram_writer.sv
// Streams Y, Cb and Cr 8x8 blocks row by row into the block SRAM, one 512-bit
// word per block, at the interleaved address 3*block + comp.
module block_sram_writer #(
  parameter int unsigned BLOCKS_PER_COMP = 575,
  parameter int unsigned ADDR_W          = 11,
  parameter int unsigned ROW_W           = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ROW_W-1:0]   in_row,
  output logic [ADDR_W-1:0]  sram_waddr,
  output logic [8*ROW_W-1:0] sram_wdata,
  output logic               sram_wen,
  output logic               busy,
  output logic               done
);

  import jpeg_pkg::*;

  localparam int unsigned BLK_W  = $clog2(BLOCKS_PER_COMP);
  localparam int unsigned WORD_W = 8 * ROW_W;

  writer_state_e state_q, state_d;

  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] waddr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              wen_q;

  logic              accept;
  logic              block_complete;
  logic              last_block;
  logic              comp_done;
  logic [WORD_W-1:0] packed_word;

  assign accept     = in_valid && in_ready;
  assign last_block = (blk_q == BLK_W'(BLOCKS_PER_COMP - 1));
  assign comp_done  = block_complete && last_block;

  block_row_packer #(
    .ROW_W (ROW_W),
    .ROWS  (8)
  ) u_packer (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (state_q == StIdle),
    .accept         (accept),
    .row            (in_row),
    .packed_word    (packed_word),
    .block_complete (block_complete)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StRunY;
      StRunY:   if (comp_done) state_d = StRunCb;
      StRunCb:  if (comp_done) state_d = StRunCr;
      StRunCr:  if (comp_done) state_d = StLastWr;
      StLastWr: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      StIdle:                    busy     = 1'b0;
      StRunY, StRunCb, StRunCr:  in_ready = 1'b1;
      StDone:                    done     = 1'b1;
      default:                   ;
    endcase
  end

  // Block count and address advance together; on a component change the
  // address is reloaded with the offset of the component being entered.
  always_comb begin
    blk_d  = blk_q;
    addr_d = addr_q;
    if (state_q == StIdle) begin
      blk_d  = '0;
      addr_d = ADDR_W'(COMP_Y);
    end else if (block_complete) begin
      if (last_block) begin
        blk_d  = '0;
        addr_d = ADDR_W'(comp_of(state_d));
      end else begin
        blk_d  = blk_q + BLK_W'(1);
        addr_d = addr_q + ADDR_W'(NUM_COMPS);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q  <= '0;
      addr_q <= '0;
    end else begin
      blk_q  <= blk_d;
      addr_q <= addr_d;
    end
  end

  // SRAM port registers hold the last word between write strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b1;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q <= !block_complete;
      if (block_complete) begin
        waddr_q <= addr_q;
        wdata_q <= packed_word;
      end
    end
  end

  assign sram_wen   = wen_q;
  assign sram_waddr = waddr_q;
  assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_block_sram_writer.sv
// Self-checking bench for block_sram_writer: a directed vector table, then
// full frames checked cycle by cycle against a frame-level reference model.
module tb_block_sram_writer;

  localparam int unsigned NBLK   = 575;
  localparam int unsigned NROWS  = 3 * NBLK * 8;
  localparam int unsigned NWR    = 3 * NBLK;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_row;
  logic [10:0]  sram_waddr;
  logic [511:0] sram_wdata;
  logic         sram_wen;
  logic         busy;
  logic         done;

  block_sram_writer #(
    .BLOCKS_PER_COMP (NBLK),
    .ADDR_W          (11),
    .ROW_W           (64)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_row     (in_row),
    .sram_waddr (sram_waddr),
    .sram_wdata (sram_wdata),
    .sram_wen   (sram_wen),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, frame level: 0 idle, 1 streaming, 2 final write, 3 done.
  int           m_mode;
  int           m_rows;
  int           m_wr;
  logic [63:0]  m_q[$];
  logic [10:0]  m_addr;
  logic [511:0] m_data;
  int           seen_wr;
  int           seen_done;

  task automatic model_reset();
    m_mode = 0;
    m_rows = 0;
    m_wr   = 0;
    m_q.delete();
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic cycle(input bit s, input bit v, input logic [63:0] r);
    bit acc;
    bit wr;
    int a;
    start    = s;
    in_valid = v;
    in_row   = r;
    acc      = v && (m_mode == 1);
    @(posedge clk);
    #1;
    wr = 1'b0;
    case (m_mode)
      0: if (s) begin
        m_mode = 1;
        m_rows = 0;
        m_wr   = 0;
        m_q.delete();
      end
      1: if (acc) begin
        m_q.push_back(r);
        m_rows++;
        if (m_q.size() == 8) begin
          wr = 1'b1;
          for (int i = 0; i < 8; i++) m_data[511-64*i -: 64] = m_q[i];
          a      = 3 * (m_wr % NBLK) + m_wr / NBLK;
          m_addr = 11'(a);
          m_wr++;
          m_q.delete();
          if (m_rows == NROWS) m_mode = 2;
        end
      end
      2: m_mode = 3;
      default: m_mode = 0;
    endcase
    chk("in_ready", in_ready, m_mode == 1);
    chk("busy", busy, m_mode != 0);
    chk("done", done, m_mode == 3);
    chk("sram_wen", sram_wen, !wr);
    chk("sram_waddr", sram_waddr, m_addr);
    chk("sram_wdata", sram_wdata, m_data);
    if (!sram_wen) seen_wr++;
    if (done) seen_done++;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  typedef struct {
    bit          start;
    bit          valid;
    logic [63:0] row;
    bit          ready;
    bit          busy;
    bit          wen;
    logic [10:0] addr;
    logic [63:0] hi;
    logic [63:0] lo;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [63:0] base;
    logic [63:0] inc;
    logic [63:0] row7;
    int budget;

    base = 64'h0001020304050607;
    inc  = 64'h0808080808080808;
    row7 = base + 7 * inc;

    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_row   = '0;
    seen_wr  = 0;
    seen_done = 0;
    model_reset();

    // Vector table: idle row ignored, start, one block, hold, ignored start.
    tbl[0] = '{0, 1, 64'hDEADBEEFCAFEF00D, 0, 0, 1, 11'd0, 64'h0, 64'h0};
    tbl[1] = '{1, 1, 64'hFFFFFFFFFFFFFFFF, 1, 1, 1, 11'd0, 64'h0, 64'h0};
    for (int r = 0; r < 8; r++) begin
      tbl[2+r] = '{0, 1, base + r * inc, 1, 1, (r != 7), 11'd0,
                   (r == 7) ? base : 64'h0, (r == 7) ? row7 : 64'h0};
    end
    tbl[10] = '{0, 0, 64'h0, 1, 1, 1, 11'd0, base, row7};
    tbl[11] = '{1, 0, 64'h0, 1, 1, 1, 11'd0, base, row7};

    #12;
    chk("reset sram_wen", sram_wen, 1'b1);
    chk("reset in_ready", in_ready, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset sram_waddr", sram_waddr, 11'd0);
    chk("reset sram_wdata", sram_wdata, 512'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      start    = tbl[i].start;
      in_valid = tbl[i].valid;
      in_row   = tbl[i].row;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d in_ready", i), in_ready, tbl[i].ready);
      chk($sformatf("tbl%0d busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d sram_wen", i), sram_wen, tbl[i].wen);
      chk($sformatf("tbl%0d sram_waddr", i), sram_waddr, tbl[i].addr);
      chk($sformatf("tbl%0d wdata_hi", i), sram_wdata[511:448], tbl[i].hi);
      chk($sformatf("tbl%0d wdata_lo", i), sram_wdata[63:0], tbl[i].lo);
    end

    // Full frame, continuous valid, with a stray start in the Cb component.
    #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(1, 0, '0);
    seen_wr   = 0;
    seen_done = 0;
    for (int i = 0; i < int'(NROWS); i++) begin
      cycle(i == int'(NBLK) * 8 + 100, 1, {$urandom, $urandom});
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, '0);
    chk("frame write count", seen_wr, NWR);
    chk("frame done count", seen_done, 1);

    // Restart after done, random valid gaps.
    seen_wr   = 0;
    seen_done = 0;
    cycle(1, 0, '0);
    budget = 4 * NROWS;
    while (m_mode == 1 && budget > 0) begin
      cycle(0, 1'($urandom_range(0, 1)), {$urandom, $urandom});
      budget--;
    end
    chk("random frame finished in budget", budget > 0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(0, 0, '0);
    chk("random write count", seen_wr, NWR);
    chk("random done count", seen_done, 1);

    // Asynchronous reset after five rows of block 3.
    cycle(1, 0, '0);
    for (int i = 0; i < 29; i++) cycle(0, 1, {$urandom, $urandom});
    #2 rst_n = 1'b0;
    #1;
    chk("async rst sram_wen", sram_wen, 1'b1);
    chk("async rst in_ready", in_ready, 1'b0);
    chk("async rst busy", busy, 1'b0);
    model_reset();
    for (int i = 0; i < 4; i++) cycle(0, 1, {$urandom, $urandom});
    rst_n = 1'b1;
    cycle(0, 1, {$urandom, $urandom});
    cycle(1, 0, '0);
    for (int i = 0; i < 8; i++) cycle(0, 1, {$urandom, $urandom});
    chk("post reset write addr", sram_waddr, 11'd0);
    cycle(0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
